// File: rtl/fu_arith_issue.sv
`default_nettype none
// ============================================================================
// Module   : fu_arith_issue
// Purpose  : Reservation station, oldest-ready select and registered issue
//            stage for the arithmetic FU. Define FU_ARITH_ISSUE_STATS_EN to
//            add the stat_issued / stat_stalled counters.
// Revision : 1.0 - initial release
// ============================================================================
module fu_arith_issue #(
  parameter int DEPTH = 4,
  parameter int PRN_W = 7,
  parameter int ID_W  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [31:0]                disp_inst,
  input  logic [ID_W-1:0]            disp_inst_id,
  input  logic [PRN_W-1:0]           disp_out_prn,
  input  logic [2*PRN_W-1:0]         disp_src_prn,
  input  logic [1:0]                 disp_src_rdy,
  input  logic [127:0]               disp_src_val,
  input  logic                       cdb_valid,
  input  logic [PRN_W-1:0]           cdb_prn,
  input  logic [63:0]                cdb_data,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [31:0]                iss_inst,
  output logic [127:0]               iss_op,
  output logic [PRN_W-1:0]           iss_out_prn,
  output logic [ID_W-1:0]            iss_inst_id,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef FU_ARITH_ISSUE_STATS_EN
  ,
  output logic [31:0]                stat_issued,
  output logic [31:0]                stat_stalled
`endif
);

  localparam int c_OCC_W = $clog2(DEPTH+1);
  localparam int c_IDX_W = $clog2(DEPTH);

  // Entry storage
  logic [DEPTH-1:0]   r_valid;
  logic [31:0]        r_inst     [DEPTH];
  logic [ID_W-1:0]    r_id       [DEPTH];
  logic [PRN_W-1:0]   r_out_prn  [DEPTH];
  logic [PRN_W-1:0]   r_src_prn  [DEPTH][2];
  logic [1:0]         r_src_rdy  [DEPTH];
  logic [63:0]        r_src_val  [DEPTH][2];
  // r_older[j][i] is set when entry j was dispatched before entry i
  logic [DEPTH-1:0]   r_older    [DEPTH];

  logic [c_OCC_W-1:0] r_occ;
  logic               r_iss_valid;
  logic [31:0]        r_iss_inst;
  logic [127:0]       r_iss_op;
  logic [PRN_W-1:0]   r_iss_out_prn;
  logic [ID_W-1:0]    r_iss_inst_id;

  logic [DEPTH-1:0]   w_rdy;
  logic [DEPTH-1:0]   w_grant;
  logic [1:0]         w_hit      [DEPTH];
  logic [c_IDX_W-1:0] w_sel_idx;
  logic               w_sel_any;
  logic [c_IDX_W-1:0] w_free_idx;
  logic               w_adv;
  logic               w_issue;
  logic               w_disp_fire;
  logic [1:0]         w_disp_hit;
  logic [63:0]        w_disp_val [2];

  // Per-entry readiness and CDB source match
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign w_rdy[gi] = r_valid[gi] & (&r_src_rdy[gi]);
    for (genvar gs = 0; gs < 2; gs++) begin : g_src
      assign w_hit[gi][gs] = cdb_valid && !r_src_rdy[gi][gs] &&
                             (cdb_prn == r_src_prn[gi][gs]);
    end
  end

  // A source not yet ready at dispatch can still catch a same-cycle broadcast
  for (genvar gs = 0; gs < 2; gs++) begin : g_disp_src
    assign w_disp_hit[gs] = cdb_valid && !disp_src_rdy[gs] &&
                            (cdb_prn == disp_src_prn[gs*PRN_W +: PRN_W]);
    assign w_disp_val[gs] = w_disp_hit[gs] ? cdb_data : disp_src_val[gs*64 +: 64];
  end

  // Oldest ready entry wins: no other ready entry is older than it
  always_comb begin
    w_grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_grant[i] = w_rdy[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && w_rdy[j] && r_older[j][i]) begin
          w_grant[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_sel_idx = '0;
    w_sel_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) begin
        w_sel_idx = c_IDX_W'(i);
        w_sel_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_idx = c_IDX_W'(i);
      end
    end
  end

  assign disp_ready  = rst && (r_occ < c_OCC_W'(DEPTH));
  assign w_disp_fire = disp_valid && disp_ready;
  assign w_adv       = !r_iss_valid || iss_ready;
  assign w_issue     = w_adv && w_sel_any;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int s = 0; s < 2; s++) begin
          if (r_valid[i] && w_hit[i][s]) begin
            r_src_rdy[i][s] <= 1'b1;
            r_src_val[i][s] <= cdb_data;
          end
        end
      end
      if (w_issue) begin
        r_valid[w_sel_idx] <= 1'b0;
      end
      if (w_disp_fire) begin
        r_valid[w_free_idx]   <= 1'b1;
        r_inst[w_free_idx]    <= disp_inst;
        r_id[w_free_idx]      <= disp_inst_id;
        r_out_prn[w_free_idx] <= disp_out_prn;
        r_src_rdy[w_free_idx] <= disp_src_rdy | w_disp_hit;
        for (int s = 0; s < 2; s++) begin
          r_src_prn[w_free_idx][s] <= disp_src_prn[s*PRN_W +: PRN_W];
          r_src_val[w_free_idx][s] <= w_disp_val[s];
        end
        // New entry is younger than everything held; its own row is cleared last
        for (int j = 0; j < DEPTH; j++) begin
          r_older[j][w_free_idx] <= 1'b1;
        end
        r_older[w_free_idx] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_iss_valid   <= 1'b0;
      r_iss_inst    <= '0;
      r_iss_op      <= '0;
      r_iss_out_prn <= '0;
      r_iss_inst_id <= '0;
    end else if (flush) begin
      r_iss_valid <= 1'b0;
    end else if (w_adv) begin
      r_iss_valid <= w_sel_any;
      if (w_sel_any) begin
        r_iss_inst    <= r_inst[w_sel_idx];
        r_iss_op      <= {r_src_val[w_sel_idx][1], r_src_val[w_sel_idx][0]};
        r_iss_out_prn <= r_out_prn[w_sel_idx];
        r_iss_inst_id <= r_id[w_sel_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_occ <= '0;
    end else begin
      case ({w_disp_fire, w_issue})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign iss_valid   = r_iss_valid;
  assign iss_inst    = r_iss_inst;
  assign iss_op      = r_iss_op;
  assign iss_out_prn = r_iss_out_prn;
  assign iss_inst_id = r_iss_inst_id;
  assign occupancy   = r_occ;

`ifdef FU_ARITH_ISSUE_STATS_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_stalled;

  // Saturating counters; flush deliberately does not touch them
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stat_issued  <= '0;
      r_stat_stalled <= '0;
    end else begin
      if (r_iss_valid && iss_ready && (r_stat_issued != 32'hFFFF_FFFF)) begin
        r_stat_issued <= r_stat_issued + 32'd1;
      end
      if (r_iss_valid && !iss_ready && (r_stat_stalled != 32'hFFFF_FFFF)) begin
        r_stat_stalled <= r_stat_stalled + 32'd1;
      end
    end
  end

  assign stat_issued  = r_stat_issued;
  assign stat_stalled = r_stat_stalled;
`endif

endmodule
`default_nettype wire

// File: doc/fu_arith_issue.md
Name: fu_arith_issue

Overview:
- Reservation station and issue scheduler that feeds the arithmetic functional unit (ADD/ADDS/SUB/SUBS/CMP).
- Accepts renamed instructions from dispatch and holds up to DEPTH of them.
- Captures source operands from the common data bus (CDB).
- Issues the oldest fully-ready entry into a registered issue stage that drives the FU's inst/op/out_prn/inst_id inputs under a valid/ready handshake.

Parameters:
DEPTH, 4, number of reservation-station entries (2..16)
PRN_W, 7, physical register number width
ID_W, 6, instruction id (ROB tag) width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk)
flush  in  1  squash all entries and the issue register
disp_valid  in  1  dispatch request
disp_ready  out  1  an entry is free
disp_inst  in  32  instruction word
disp_inst_id  in  ID_W  instruction id
disp_out_prn  in  PRN_W  destination prn
disp_src_prn  in  2*PRN_W  source prns; [PRN_W-1:0] = src0
disp_src_rdy  in  2  source already available (dispatcher sets 1 for unused/imm sources)
disp_src_val  in  128  source values, valid where rdy=1; [63:0] = src0
cdb_valid  in  1  result broadcast valid
cdb_prn  in  PRN_W  broadcast prn
cdb_data  in  64  broadcast value
iss_valid  out  1  issue register holds an instruction
iss_ready  in  1  FU accepts (fu_ready)
iss_inst  out  32  to fu.inst
iss_op  out  128  to fu.op[0], fu.op[1]
iss_out_prn  out  PRN_W  to fu.out_prn
iss_inst_id  out  ID_W  to fu.inst_id
occupancy  out  $clog2(DEPTH+1)  entries currently held (excluding issue register)

Behaviour:
- Reset (rst==0 at posedge):
  - All entries invalid; iss_valid=0; occupancy=0.
  - disp_ready=0 while rst==0; disp_ready=1 from the first cycle after release.
  - iss_* data outputs reset to 0.
- Dispatch:
  - Accepted when disp_valid && disp_ready at posedge.
  - Written into any free entry with an age stamp newer than every held entry.
  - disp_ready = (occupancy < DEPTH), computed from current state only. A slot freed in the same cycle is not reusable until the next cycle.
- Wakeup (every cycle, all valid entries, per source):
  - If cdb_valid && cdb_prn==src_prn && !src_rdy: latch cdb_data and set src_rdy.
  - Also applies to the entry being dispatched in the same cycle. A same-cycle CDB match overrides disp_src_rdy=0, so no wakeup is lost.
- Select:
  - Ready entry = valid && both src_rdy (state before this cycle's wakeup).
  - Pick the oldest ready entry by dispatch order.
  - Selection occurs only when the issue register is free or draining: !iss_valid || iss_ready.
- Issue register:
  - On advance, load the selected entry (or clear iss_valid if none) and free the entry in the same edge.
  - While iss_valid && !iss_ready: all iss_* outputs held stable, no entry freed.
- Latency:
  - Dispatch with both sources ready accepted at edge E: entry valid after E, selected in the next cycle, iss_valid high after edge E+1. Minimum 2 cycles from disp_valid to iss_valid.
  - A CDB wakeup at edge E gives issue after E+1.
  - Back-to-back issue: 1 per cycle when iss_ready held high.
- Occupancy: +1 on accepted dispatch, -1 on entry moved to the issue register; both in the same cycle leaves it unchanged.
- Flush:
  - At posedge with flush=1: all entries invalid, iss_valid=0, occupancy=0.
  - A dispatch in the same cycle is dropped.
  - Flush has priority over everything except reset.
- Age stamps: relative ordering only; no wrap-around hazard allowed (age matrix or collapsing order).

Optional Feature:
- Macro: FU_ARITH_ISSUE_STATS_EN.
- Defined: adds outputs stat_issued (32) and stat_stalled (32).
  - stat_issued increments on each iss_valid && iss_ready.
  - stat_stalled increments each cycle iss_valid && !iss_ready.
  - Both saturate at 0xFFFFFFFF, clear on reset, and are unaffected by flush.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then dispatch ADD (inst 0x91000C20, src_rdy=11, src0=5, out_prn=9, id=3), iss_ready=1 -> iss_valid 2 cycles later with iss_op[63:0]=5, iss_out_prn=9, iss_inst_id=3; occupancy returns to 0.
- Dispatch A (src0 prn 12 not ready) then B (all ready) -> B issues first; cdb_valid prn=12 data=0x77 -> A issues next cycle+1 with op0=0x77.
- Dispatch with src1 prn 20 not ready in the same cycle as cdb prn=20 data=0xAB -> entry issues with op1=0xAB; no hang.
- Fill 4 ready entries with iss_ready=0 -> disp_ready=0 at occupancy 4, iss_* stable. Raise iss_ready -> 4 issues on consecutive cycles in dispatch order, then disp_ready=1.
- Flush with 3 entries held and iss_valid=1 plus a simultaneous dispatch -> next cycle iss_valid=0, occupancy=0, dispatched instruction never issues.
- FU_ARITH_ISSUE_STATS_EN: 2 stall cycles then 3 issues -> stat_stalled=2, stat_issued=3; flush leaves both unchanged.
